pc_sequencer: RTL and testbench

//  Parametrised program-counter sequencer; successor to the fixed 8-bit free-running PC.

---
 rtl/pc_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Parametrised program-counter sequencer. It issues fetch addresses for the
//   instruction ROM and supports stall, absolute jump and PC-relative branch.
//   o_PC comes straight from a register and has no combinational path from
//   any input. The return-address stack for call/return is optional.
//
//   Compile-time option:
//     PC_RAS_EN  - when defined, adds i_CALL, i_RET, o_RAS_EMPTY, o_RAS_OVF
//                  and the circular return-address stack.
//
//   Parameters:
//     WIDTH      PC width in bits (2..32)
//     RESET_VEC  value loaded into o_PC on reset
//     STEP       sequential increment per advancing cycle
//     RAS_DEPTH  return-address stack entries (power of 2, >= 2)
//
//   Ports:
//     i_CLK        clock, all state updates on posedge
//     i_RESET      asynchronous, active-low reset
//     i_STALL      hold PC this cycle (redirects override it)
//     i_JUMP       load i_JUMP_ADDR
//     i_JUMP_ADDR  absolute target (also the call target)
//     i_BRANCH     o_PC <= o_PC + i_BR_OFFSET (two's complement, wraps)
//     i_BR_OFFSET  signed branch offset
//     i_CALL       (PC_RAS_EN) jump to i_JUMP_ADDR, push o_PC+STEP
//     i_RET        (PC_RAS_EN) pop top of stack into PC
//     o_PC         current fetch address
//     o_WRAP       1-cycle pulse: sequential increment wrapped past 2^WIDTH-1
//     o_RAS_EMPTY  (PC_RAS_EN) stack holds no entries
//     o_RAS_OVF    (PC_RAS_EN) sticky, a push happened while full
//
//   Priority per edge: RET > CALL > JUMP > BRANCH > STALL > increment.
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned      STEP      = 1,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             i_CLK,
    input  logic             i_RESET,
    input  logic             i_STALL,
    input  logic             i_JUMP,
    input  logic [WIDTH-1:0] i_JUMP_ADDR,
    input  logic             i_BRANCH,
    input  logic [WIDTH-1:0] i_BR_OFFSET,
`ifdef PC_RAS_EN
    input  logic             i_CALL,
    input  logic             i_RET,
    output logic             o_RAS_EMPTY,
    output logic             o_RAS_OVF,
`endif
    output logic [WIDTH-1:0] o_PC,
    output logic             o_WRAP
);

    logic [WIDTH-1:0] r_pc;
    logic             r_wrap;
    logic [WIDTH:0]   w_inc;        // extra MSB is the carry out, i.e. the wrap flag
    logic [WIDTH-1:0] w_next_pc;
    logic             w_next_wrap;

    assign w_inc = {1'b0, r_pc} + (WIDTH+1)'(STEP);

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_sp;         // next slot to write; top of stack is r_sp-1
    logic [PTR_W:0]   r_count;      // valid entries, saturates at RAS_DEPTH
    logic             r_ovf;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic [PTR_W-1:0] w_top_idx;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (PTR_W+1)'(RAS_DEPTH));
    assign w_top_idx = r_sp - PTR_W'(1);
`endif

    always_comb begin
        w_next_pc   = w_inc[WIDTH-1:0];
        w_next_wrap = w_inc[WIDTH];
`ifdef PC_RAS_EN
        w_push      = 1'b0;
        w_pop       = 1'b0;
`endif
        if (i_JUMP) begin
            w_next_pc   = i_JUMP_ADDR;
            w_next_wrap = 1'b0;
        end else if (i_BRANCH) begin
            w_next_pc   = r_pc + i_BR_OFFSET;
            w_next_wrap = 1'b0;
        end else if (i_STALL) begin
            w_next_pc   = r_pc;
            w_next_wrap = 1'b0;
        end
`ifdef PC_RAS_EN
        // Stack controls sit above jump/branch, so they are resolved last and
        // overwrite whatever the lower-priority chain chose.
        if (i_RET) begin
            // A return with nothing on the stack just advances; it still counts
            // as a redirect, so it never raises o_WRAP.
            w_next_wrap = 1'b0;
            if (w_empty) begin
                w_next_pc = w_inc[WIDTH-1:0];
            end else begin
                w_next_pc = r_ras[w_top_idx];
                w_pop     = 1'b1;
            end
        end else if (i_CALL) begin
            w_next_pc   = i_JUMP_ADDR;
            w_next_wrap = 1'b0;
            w_push      = 1'b1;
        end
`endif
    end

    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            r_pc   <= RESET_VEC;
            r_wrap <= 1'b0;
        end else begin
            r_pc   <= w_next_pc;
            r_wrap <= w_next_wrap;
        end
    end

    assign o_PC   = r_pc;
    assign o_WRAP = r_wrap;

`ifdef PC_RAS_EN
    // When full, a push lands on the oldest slot (r_sp has wrapped onto it),
    // so the count stays at RAS_DEPTH and only the sticky flag records it.
    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            r_sp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_pop) begin
            r_sp    <= r_sp - PTR_W'(1);
            r_count <= r_count - (PTR_W+1)'(1);
        end else if (w_push) begin
            r_sp <= r_sp + PTR_W'(1);
            if (w_full) begin
                r_ovf <= 1'b1;
            end else begin
                r_count <= r_count + (PTR_W+1)'(1);
            end
        end
    end

    // Entry storage needs no reset: r_count alone decides which slots are live.
    always_ff @(posedge i_CLK) begin
        if (w_push) begin
            r_ras[r_sp] <= w_inc[WIDTH-1:0];
        end
    end

    assign o_RAS_EMPTY = w_empty;
    assign o_RAS_OVF   = r_ovf;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//   Two instances: an 8-bit sequencer (RESET_VEC 0x10, RAS_DEPTH 2) and a
//   4-bit one (RESET_VEC 0xE). A reference model built from plain modular
//   arithmetic and a queue-based stack follows both. One compare process
//   checks every output on each falling edge. Directed steps pin literal
//   values, and randomized traffic follows them.
//   Works with PC_RAS_EN defined or undefined.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int DEPTH8 = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    logic       st8 = 1'b0, jp8 = 1'b0, br8 = 1'b0, ca8 = 1'b0, re8 = 1'b0;
    logic [7:0] ja8 = '0, bo8 = '0;
    logic       st4 = 1'b0, jp4 = 1'b0, br4 = 1'b0;
    logic [3:0] ja4 = '0, bo4 = '0;

    logic [7:0] pc8;
    logic       wrap8;
    logic [3:0] pc4;
    logic       wrap4;
`ifdef PC_RAS_EN
    logic       empty8, ovf8, empty4, ovf4;
`endif

    pc_sequencer #(.WIDTH(8), .RESET_VEC(8'h10), .STEP(1), .RAS_DEPTH(DEPTH8)) u_dut8 (
        .i_CLK       (clk),
        .i_RESET     (rst_n),
        .i_STALL     (st8),
        .i_JUMP      (jp8),
        .i_JUMP_ADDR (ja8),
        .i_BRANCH    (br8),
        .i_BR_OFFSET (bo8),
`ifdef PC_RAS_EN
        .i_CALL      (ca8),
        .i_RET       (re8),
        .o_RAS_EMPTY (empty8),
        .o_RAS_OVF   (ovf8),
`endif
        .o_PC        (pc8),
        .o_WRAP      (wrap8)
    );

    pc_sequencer #(.WIDTH(4), .RESET_VEC(4'hE), .STEP(1), .RAS_DEPTH(4)) u_dut4 (
        .i_CLK       (clk),
        .i_RESET     (rst_n),
        .i_STALL     (st4),
        .i_JUMP      (jp4),
        .i_JUMP_ADDR (ja4),
        .i_BRANCH    (br4),
        .i_BR_OFFSET (bo4),
`ifdef PC_RAS_EN
        .i_CALL      (1'b0),
        .i_RET       (1'b0),
        .o_RAS_EMPTY (empty4),
        .o_RAS_OVF   (ovf4),
`endif
        .o_PC        (pc4),
        .o_WRAP      (wrap4)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_pc8   = 'h10;
    int m_pc4   = 'hE;
    bit m_wrap8 = 1'b0;
    bit m_wrap4 = 1'b0;
    bit m_ovf   = 1'b0;
    bit m_done  = 1'b0;
    int m_stk[$];

    // Jump/branch/stall/increment for a PC of w bits, step 1.
    function automatic void plain_step(input int w, inout int pc, output bit wrap,
                                       input bit st, input bit jp, input bit br,
                                       input int ja, input int bo);
        int m = 1 << w;
        wrap = 1'b0;
        if (jp)       pc = ja % m;
        else if (br)  pc = (pc + bo) % m;
        else if (!st) begin
            wrap = (pc + 1) >= m;
            pc   = (pc + 1) % m;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc8 = 'h10; m_wrap8 = 1'b0; m_ovf = 1'b0; m_stk.delete();
            m_pc4 = 'hE;  m_wrap4 = 1'b0;
        end else begin
            m_done  = 1'b0;
            m_wrap8 = 1'b0;
`ifdef PC_RAS_EN
            if (re8) begin
                if (m_stk.size() > 0) m_pc8 = m_stk.pop_back();
                else                  m_pc8 = (m_pc8 + 1) % 256;
                m_done = 1'b1;
            end else if (ca8) begin
                m_stk.push_back((m_pc8 + 1) % 256);
                if (m_stk.size() > DEPTH8) begin
                    void'(m_stk.pop_front());
                    m_ovf = 1'b1;
                end
                m_pc8  = int'(ja8);
                m_done = 1'b1;
            end
`endif
            if (!m_done) plain_step(8, m_pc8, m_wrap8, st8, jp8, br8, int'(ja8), int'(bo8));
            plain_step(4, m_pc4, m_wrap4, st4, jp4, br4, int'(ja4), int'(bo4));
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc8",   32'(pc8),   32'(m_pc8));
            check("wrap8", 32'(wrap8), 32'(m_wrap8));
            check("pc4",   32'(pc4),   32'(m_pc4));
            check("wrap4", 32'(wrap4), 32'(m_wrap4));
`ifdef PC_RAS_EN
            check("empty8", 32'(empty8), 32'(m_stk.size() == 0));
            check("ovf8",   32'(ovf8),   32'(m_ovf));
            check("empty4", 32'(empty4), 32'd1);
            check("ovf4",   32'(ovf4),   32'd0);
`endif
        end
    end

    // ---------------- driver ----------------
    // Inputs change on the falling edge and hold across the next rising edge.
    task automatic apply(input logic st, input logic jp, input logic br, input logic ca,
                         input logic re, input logic [7:0] ja, input logic [7:0] bo);
        st8 = st; jp8 = jp; br8 = br; ca8 = ca; re8 = re; ja8 = ja; bo8 = bo;
        @(negedge clk);
    endtask

    initial begin
        int r;
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pc8",   32'(pc8),   32'h10);
        check("rst_wrap8", 32'(wrap8), 32'h0);
        check("rst_pc4",   32'(pc4),   32'hE);
`ifdef PC_RAS_EN
        check("rst_empty", 32'(empty8), 32'h1);
        check("rst_ovf",   32'(ovf8),   32'h0);
`endif
        rst_n = 1'b1;

        // Idle advance from reset; the 4-bit unit wraps, then stalls.
        apply(0, 0, 0, 0, 0, 8'h00, 8'h00);
        check("t1_pc_a", 32'(pc8), 32'h11);
        check("t2_pc_a", 32'(pc4), 32'hF);
        check("t2_wr_a", 32'(wrap4), 32'h0);
        apply(0, 0, 0, 0, 0, 8'h00, 8'h00);
        check("t1_pc_b", 32'(pc8), 32'h12);
        check("t2_pc_b", 32'(pc4), 32'h0);
        check("t2_wr_b", 32'(wrap4), 32'h1);
        st4 = 1'b1;
        apply(0, 0, 0, 0, 0, 8'h00, 8'h00);
        check("t1_pc_c", 32'(pc8), 32'h13);
        check("t1_wr_c", 32'(wrap8), 32'h0);
        check("t2_pc_c", 32'(pc4), 32'h0);
        check("t2_wr_c", 32'(wrap4), 32'h0);
        st4 = 1'b0;

        // Branch backwards, jump overriding stall, jump beating branch.
        apply(0, 1, 0, 0, 0, 8'h20, 8'h00);
        apply(0, 0, 1, 0, 0, 8'h00, 8'hF8);
        check("t3_branch", 32'(pc8), 32'h18);
        apply(1, 1, 0, 0, 0, 8'h40, 8'h00);
        check("t3_jmp_stall", 32'(pc8), 32'h40);
        apply(0, 1, 0, 0, 0, 8'h05, 8'h00);
        apply(0, 1, 1, 0, 0, 8'h80, 8'h02);
        check("t4_jmp_win", 32'(pc8), 32'h80);

        // 8-bit wrap, and a branch crossing the top that must not pulse o_WRAP.
        apply(0, 1, 0, 0, 0, 8'hFF, 8'h00);
        apply(0, 0, 0, 0, 0, 8'h00, 8'h00);
        check("wrap8_pc", 32'(pc8), 32'h00);
        check("wrap8_on", 32'(wrap8), 32'h1);
        apply(0, 0, 0, 0, 0, 8'h00, 8'h00);
        check("wrap8_off", 32'(wrap8), 32'h0);
        apply(0, 1, 0, 0, 0, 8'hFE, 8'h00);
        apply(0, 0, 1, 0, 0, 8'h00, 8'h04);
        check("br_wrap_pc", 32'(pc8), 32'h02);
        check("br_wrap_no", 32'(wrap8), 32'h0);

`ifdef PC_RAS_EN
        // Call chain overflowing a 2-entry stack, then unwinding past empty.
        apply(0, 1, 0, 0, 0, 8'h05, 8'h00);
        apply(0, 0, 0, 1, 0, 8'h40, 8'h00);
        apply(0, 0, 0, 1, 0, 8'h60, 8'h00);
        check("t5_ovf_pre", 32'(ovf8), 32'h0);
        apply(0, 0, 0, 1, 0, 8'h70, 8'h00);
        check("t5_pc_call", 32'(pc8), 32'h70);
        check("t5_ovf", 32'(ovf8), 32'h1);
        apply(0, 0, 0, 0, 1, 8'h00, 8'h00);
        check("t5_ret1", 32'(pc8), 32'h61);
        apply(0, 0, 0, 0, 1, 8'h00, 8'h00);
        check("t5_ret2", 32'(pc8), 32'h41);
        check("t5_empty", 32'(empty8), 32'h1);
        apply(0, 0, 0, 0, 1, 8'h00, 8'h00);
        check("t5_ret_empty", 32'(pc8), 32'h42);
        apply(0, 0, 0, 1, 1, 8'h90, 8'h00);
        check("call_ret_pc", 32'(pc8), 32'h43);
        check("call_ret_empty", 32'(empty8), 32'h1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r   = $urandom_range(0, 99);
            st8 = ($urandom_range(0, 3) == 0);
            jp8 = (r < 10);
            br8 = (r >= 10 && r < 20);
            ca8 = (r >= 20 && r < 30);
            re8 = (r >= 30 && r < 38);
            if ($urandom_range(0, 15) == 0) begin
                ca8 = 1'b1; re8 = 1'b1; jp8 = 1'b1; br8 = 1'b1;
            end
            ja8 = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'hF0, 8'hFF))
                                              : 8'($urandom_range(0, 255));
            bo8 = 8'($urandom_range(0, 255));
            r   = $urandom_range(0, 99);
            st4 = ($urandom_range(0, 3) == 0);
            jp4 = (r < 8);
            br4 = (r >= 8 && r < 20);
            ja4 = 4'($urandom_range(0, 15));
            bo4 = 4'($urandom_range(0, 15));
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a stalled cycle.
        st8 = 1'b1; jp8 = 1'b0; br8 = 1'b0; ca8 = 1'b0; re8 = 1'b0;
        st4 = 1'b1; jp4 = 1'b0; br4 = 1'b0;
`ifdef PC_RAS_EN
        apply(1, 0, 0, 1, 0, 8'h33, 8'h00);
        apply(1, 0, 0, 1, 0, 8'h44, 8'h00);
        apply(1, 0, 0, 1, 0, 8'h55, 8'h00);
        check("t6_ovf_pre", 32'(ovf8), 32'h1);
        st8 = 1'b1; ca8 = 1'b0;
`endif
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t6_pc8", 32'(pc8), 32'h10);
        check("t6_pc4", 32'(pc4), 32'hE);
        check("t6_wrap8", 32'(wrap8), 32'h0);
`ifdef PC_RAS_EN
        check("t6_empty", 32'(empty8), 32'h1);
        check("t6_ovf", 32'(ovf8), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        st4 = 1'b0;
        apply(0, 0, 0, 0, 0, 8'h00, 8'h00);
        check("t6_after", 32'(pc8), 32'h11);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
